mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Sits directly downstream of the pipelined datapath's instruction-memory and data-memory ports; both feed it.
- Multiplexes them onto a single physical word-wide memory port that has variable latency.
- Registers the accepted request and owns the transaction until the memory responds, so later changes on the datapath side cannot disturb it.
- Returns one-cycle response pulses with registered read data.

Parameters:
ADDR_W, 16, address width of all ports
DATA_W, 16, data width of all ports
BE_W, 2, byte-enable width (DATA_W/8)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
i_mem_read  input  1  instruction fetch request (level)
i_mem_address  input  ADDR_W  fetch address
i_mem_resp  output  1  one-cycle fetch completion pulse
i_mem_rdata  output  DATA_W  fetch data, valid when i_mem_resp=1
d_mem_read  input  1  data read request (level)
d_mem_write  input  1  data write request (level)
d_mem_address  input  ADDR_W  data address
d_mem_wdata  input  DATA_W  write data
d_mem_byte_enable  input  BE_W  write byte mask
d_mem_resp  output  1  one-cycle data completion pulse
d_mem_rdata  output  DATA_W  read data, valid when d_mem_resp=1
pmem_read  output  1  physical read strobe, held until pmem_resp
pmem_write  output  1  physical write strobe, held until pmem_resp
pmem_address  output  ADDR_W  physical address (registered)
pmem_wdata  output  DATA_W  physical write data (registered)
pmem_byte_enable  output  BE_W  physical byte mask (registered; 2'b11 on reads)
pmem_resp  input  1  physical completion, one cycle
pmem_rdata  input  DATA_W  physical read data, valid with pmem_resp

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, last_grant=INST.
  - All pmem_* outputs 0; both resp outputs 0; rdata register 0.
  - Takes effect immediately, including mid-transaction; the in-flight transaction is abandoned and no resp is emitted.
- Requests: i_req=i_mem_read; d_req=d_mem_read|d_mem_write. If d_mem_read and d_mem_write are both 1, the request is a write.
- IDLE:
  - Only d_req -> grant D. Only i_req -> grant I.
  - Both -> grant the side not in last_grant (round-robin). After reset, D wins the first tie.
  - On grant, latch address, wdata, byte_enable (2'b11 for reads) and read/write type; set last_grant; go BUSY_I or BUSY_D.
  - pmem_resp in IDLE is ignored.
- BUSY_x:
  - pmem_read or pmem_write is driven from latched type; pmem_address, wdata and byte_enable come from the latch.
  - Requester inputs are ignored; deasserting or changing them (e.g. a flush) does not cancel the transaction.
  - On pmem_resp: capture pmem_rdata into the rdata register, drop the pmem strobes on the next edge, go RESP_x.
- RESP_x:
  - Assert x_mem_resp for exactly one cycle; then go IDLE.
  - The rdata register drives both i_mem_rdata and d_mem_rdata and holds its value until the next capture.
  - For writes, resp still pulses; the rdata value is unspecified-but-stable (it is the captured pmem_rdata).
- Latency:
  - Request sampled at edge N; pmem strobe is high during cycle N+1.
  - If pmem_resp arrives in cycle M, x_mem_resp is high in cycle M+1.
  - Minimum request-to-resp: 3 cycles when pmem_resp is in cycle N+1.
  - At most one transaction is outstanding.
- Back-to-back: after RESP_x the arbiter spends one cycle in IDLE before the next grant. A request held through RESP is re-evaluated in IDLE.
- Invariants:
  - pmem_read and pmem_write are never both 1.
  - i_mem_resp and d_mem_resp are never both 1.
  - Resp is never asserted in a cycle without a preceding accepted grant.

Test Plan:
- Reset then i_mem_read=1, addr 16'h0040; pmem_resp 2 cycles after strobe with rdata 16'h1234 -> pmem_read=1 with addr 16'h0040, then i_mem_resp pulses once with i_mem_rdata=16'h1234; d_mem_resp stays 0.
- After reset, i_mem_read and d_mem_read asserted together (addr 16'h0100, 16'h0200) -> D granted first (pmem_address=16'h0200), then I (16'h0100). A second simultaneous tie after that grants I first.
- d_mem_write=1, addr 16'h0300, wdata 16'hBEEF, be 2'b10 -> pmem_write=1 with those values, pmem_read=0; d_mem_resp pulses one cycle after pmem_resp.
- Grant D read at 16'h0400, then drop d_mem_read and change d_mem_address to 16'h0500 while BUSY -> pmem_address stays 16'h0400 and d_mem_resp still pulses once.
- Assert rst_n=0 mid-BUSY, then pmem_resp=1 -> pmem strobes 0 immediately, no resp pulse; next grant after release is D on a tie.
- d_mem_read=d_mem_write=1 -> write issued (pmem_write=1, pmem_read=0). pmem_resp pulsed while IDLE -> no output change.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Merges the datapath's instruction-fetch port (I) and data port (D) onto a
// single word-wide physical memory port whose latency varies. One
// transaction is in flight at a time.
//
// When a request is granted, the arbiter copies its address, data, byte
// mask and read/write type into its own registers. From then on it ignores
// the requester's inputs until the physical port responds. This means a
// pipeline flush that drops or changes a request cannot corrupt a
// transaction already on the bus.
//
// When both sides request in the same idle cycle, they take turns
// (round-robin). The first tie after reset goes to D.
//
// Ports
//   clk, rst_n                  clock; asynchronous active-low reset
//   i_mem_read/address          fetch request (level) and its address
//   i_mem_resp/rdata            one-cycle fetch completion and its data
//   d_mem_read/write/address    data request (level); write wins if both set
//   d_mem_wdata/byte_enable     write data and byte mask
//   d_mem_resp/rdata            one-cycle data completion and read data
//   pmem_read/write             physical strobes, held until pmem_resp
//   pmem_address/wdata/
//   pmem_byte_enable            registered copy of the granted request
//   pmem_resp/rdata             physical completion pulse and read data
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_mem_read,
    input  logic [ADDR_W-1:0] i_mem_address,
    output logic              i_mem_resp,
    output logic [DATA_W-1:0] i_mem_rdata,

    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_address,
    input  logic [DATA_W-1:0] d_mem_wdata,
    input  logic [BE_W-1:0]   d_mem_byte_enable,
    output logic              d_mem_resp,
    output logic [DATA_W-1:0] d_mem_rdata,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [DATA_W-1:0] pmem_wdata,
    output logic [BE_W-1:0]   pmem_byte_enable,
    input  logic              pmem_resp,
    input  logic [DATA_W-1:0] pmem_rdata
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUSY_I = 3'd1,
        BUSY_D = 3'd2,
        RESP_I = 3'd3,
        RESP_D = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                last_d_q, last_d_d;    // 1: D won the most recent grant
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [BE_W-1:0]     be_q;
    logic                wr_q;
    logic [DATA_W-1:0]   rdata_q;

    logic                i_req, d_req;
    logic                gnt_i, gnt_d;
    logic                busy;

    assign i_req = i_mem_read;
    assign d_req = d_mem_read | d_mem_write;
    assign busy  = (state_q == BUSY_I) || (state_q == BUSY_D);

    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        gnt_i    = 1'b0;
        gnt_d    = 1'b0;
        case (state_q)
            IDLE: begin
                // On a tie, D wins only if I had the previous grant.
                gnt_d = d_req && (!i_req || !last_d_q);
                gnt_i = i_req && !gnt_d;
                if (gnt_d) begin
                    state_d  = BUSY_D;
                    last_d_d = 1'b1;
                end else if (gnt_i) begin
                    state_d  = BUSY_I;
                    last_d_d = 1'b0;
                end
            end
            BUSY_I:  if (pmem_resp) state_d = RESP_I;
            BUSY_D:  if (pmem_resp) state_d = RESP_D;
            RESP_I:  state_d = IDLE;
            RESP_D:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            wr_q     <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            if (gnt_d) begin
                addr_q  <= d_mem_address;
                wdata_q <= d_mem_wdata;
                // A read always fetches the whole word; only writes use the mask.
                be_q    <= d_mem_write ? d_mem_byte_enable : {BE_W{1'b1}};
                wr_q    <= d_mem_write;
            end else if (gnt_i) begin
                addr_q  <= i_mem_address;
                wdata_q <= '0;
                be_q    <= {BE_W{1'b1}};
                wr_q    <= 1'b0;
            end
            if (busy && pmem_resp)
                rdata_q <= pmem_rdata;
        end
    end

    // The strobes depend only on registered state, so they go low on the
    // same clock edge that moves the FSM out of BUSY.
    assign pmem_read        = busy && !wr_q;
    assign pmem_write       = busy &&  wr_q;
    assign pmem_address     = addr_q;
    assign pmem_wdata       = wdata_q;
    assign pmem_byte_enable = be_q;

    assign i_mem_resp  = (state_q == RESP_I);
    assign d_mem_resp  = (state_q == RESP_D);
    assign i_mem_rdata = rdata_q;
    assign d_mem_rdata = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_mem_read;
    logic [15:0] i_mem_address;
    logic        i_mem_resp;
    logic [15:0] i_mem_rdata;
    logic        d_mem_read, d_mem_write;
    logic [15:0] d_mem_address, d_mem_wdata;
    logic [1:0]  d_mem_byte_enable;
    logic        d_mem_resp;
    logic [15:0] d_mem_rdata;
    logic        pmem_read, pmem_write;
    logic [15:0] pmem_address, pmem_wdata;
    logic [1:0]  pmem_byte_enable;
    logic        pmem_resp;
    logic [15:0] pmem_rdata;

    int errors = 0;
    int checks = 0;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .BE_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_mem_read(i_mem_read), .i_mem_address(i_mem_address),
        .i_mem_resp(i_mem_resp), .i_mem_rdata(i_mem_rdata),
        .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
        .d_mem_address(d_mem_address), .d_mem_wdata(d_mem_wdata),
        .d_mem_byte_enable(d_mem_byte_enable),
        .d_mem_resp(d_mem_resp), .d_mem_rdata(d_mem_rdata),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_byte_enable(pmem_byte_enable),
        .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
            $error("%s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Step one clock; all drives and samples happen 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobes(input string tag, input logic rd, input logic wr);
        chk({tag, ".pmem_read"},  {31'd0, pmem_read},  {31'd0, rd});
        chk({tag, ".pmem_write"}, {31'd0, pmem_write}, {31'd0, wr});
    endtask

    task automatic resps(input string tag, input logic ir, input logic dr);
        chk({tag, ".i_resp"}, {31'd0, i_mem_resp}, {31'd0, ir});
        chk({tag, ".d_resp"}, {31'd0, d_mem_resp}, {31'd0, dr});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic pulse_pmem(input logic [15:0] data);
        pmem_resp  = 1'b1;
        pmem_rdata = data;
        tick();
        pmem_resp  = 1'b0;
        pmem_rdata = 16'h0000;
    endtask

    initial begin
        i_mem_read = 0; i_mem_address = 0;
        d_mem_read = 0; d_mem_write = 0; d_mem_address = 0;
        d_mem_wdata = 0; d_mem_byte_enable = 0;
        pmem_resp = 0; pmem_rdata = 0;
        rst_n = 1'b0;
        #1;

        // ---- reset values
        tick();
        strobes("rst", 0, 0);
        resps("rst", 0, 0);
        chk("rst.addr",  {16'd0, pmem_address}, 32'h0);
        chk("rst.wdata", {16'd0, pmem_wdata}, 32'h0);
        chk("rst.be",    {30'd0, pmem_byte_enable}, 32'h0);
        chk("rst.rdata", {16'd0, i_mem_rdata}, 32'h0);
        rst_n = 1'b1;
        tick();

        // ---- single fetch; pmem answers in the second strobe cycle
        i_mem_read = 1; i_mem_address = 16'h0040;
        tick();                                   // granted
        i_mem_read = 0;
        strobes("f1.busy", 1, 0);
        chk("f1.addr", {16'd0, pmem_address}, 32'h0040);
        chk("f1.be",   {30'd0, pmem_byte_enable}, 32'h3);
        tick();
        strobes("f1.busy2", 1, 0);
        pulse_pmem(16'h1234);                     // now RESP_I
        resps("f1.resp", 1, 0);
        chk("f1.rdata", {16'd0, i_mem_rdata}, 32'h1234);
        strobes("f1.resp", 0, 0);
        tick();
        resps("f1.after", 0, 0);
        chk("f1.hold", {16'd0, i_mem_rdata}, 32'h1234);

        // ---- tie after reset: D, then I, then D (requests held throughout)
        do_reset();
        i_mem_read = 1; i_mem_address = 16'h0100;
        d_mem_read = 1; d_mem_address = 16'h0200;
        tick();
        strobes("tie1", 1, 0);
        chk("tie1.addr", {16'd0, pmem_address}, 32'h0200);
        pulse_pmem(16'hAAAA);
        resps("tie1.resp", 0, 1);
        chk("tie1.rdata", {16'd0, d_mem_rdata}, 32'hAAAA);
        tick();                                   // IDLE gap, re-evaluates tie
        resps("tie1.idle", 0, 0);
        strobes("tie1.idle", 0, 0);
        tick();
        chk("tie2.addr", {16'd0, pmem_address}, 32'h0100);
        strobes("tie2", 1, 0);
        pulse_pmem(16'hBBBB);
        resps("tie2.resp", 1, 0);
        tick();
        tick();
        chk("tie3.addr", {16'd0, pmem_address}, 32'h0200);
        i_mem_read = 0; d_mem_read = 0;
        pulse_pmem(16'hCCCC);
        resps("tie3.resp", 0, 1);
        tick();

        // ---- masked write, pmem answers in the first strobe cycle
        d_mem_write = 1; d_mem_address = 16'h0300;
        d_mem_wdata = 16'hBEEF; d_mem_byte_enable = 2'b10;
        tick();
        d_mem_write = 0;
        strobes("wr", 0, 1);
        chk("wr.addr",  {16'd0, pmem_address}, 32'h0300);
        chk("wr.wdata", {16'd0, pmem_wdata}, 32'hBEEF);
        chk("wr.be",    {30'd0, pmem_byte_enable}, 32'h2);
        pulse_pmem(16'h5A5A);
        resps("wr.resp", 0, 1);
        strobes("wr.resp", 0, 0);
        tick();
        resps("wr.after", 0, 0);

        // ---- requester drops and changes address while BUSY
        d_mem_read = 1; d_mem_address = 16'h0400;
        tick();
        d_mem_read = 0; d_mem_address = 16'h0500;
        tick();
        tick();
        strobes("flush", 1, 0);
        chk("flush.addr", {16'd0, pmem_address}, 32'h0400);
        chk("flush.be",   {30'd0, pmem_byte_enable}, 32'h3);
        pulse_pmem(16'h0F0F);
        resps("flush.resp", 0, 1);
        chk("flush.rdata", {16'd0, d_mem_rdata}, 32'h0F0F);
        tick();
        resps("flush.after", 0, 0);

        // ---- asynchronous reset in the middle of a fetch
        i_mem_read = 1; i_mem_address = 16'h0600;
        tick();
        i_mem_read = 0;
        strobes("ar.busy", 1, 0);
        #2 rst_n = 1'b0;
        #1;
        strobes("ar.async", 0, 0);
        pmem_resp = 1; pmem_rdata = 16'h7777;
        tick();
        pmem_resp = 0;
        resps("ar.noresp", 0, 0);
        chk("ar.rdata", {16'd0, i_mem_rdata}, 32'h0);
        rst_n = 1'b1;
        tick();
        resps("ar.noresp2", 0, 0);
        i_mem_read = 1; i_mem_address = 16'h0700;
        d_mem_read = 1; d_mem_address = 16'h0800;
        tick();
        i_mem_read = 0; d_mem_read = 0;
        chk("ar.tie", {16'd0, pmem_address}, 32'h0800);
        pulse_pmem(16'h1111);
        resps("ar.resp", 0, 1);
        tick();

        // ---- read+write together is a write
        d_mem_read = 1; d_mem_write = 1; d_mem_address = 16'h0900;
        d_mem_wdata = 16'hCAFE; d_mem_byte_enable = 2'b01;
        tick();
        d_mem_read = 0; d_mem_write = 0;
        strobes("rw", 0, 1);
        chk("rw.be", {30'd0, pmem_byte_enable}, 32'h1);
        pulse_pmem(16'h2222);
        resps("rw.resp", 0, 1);
        tick();

        // ---- pmem_resp in IDLE does nothing
        pulse_pmem(16'h9999);
        resps("idle.resp", 0, 0);
        strobes("idle", 0, 0);
        chk("idle.rdata", {16'd0, d_mem_rdata}, 32'h2222);
        tick();
        resps("idle.resp2", 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
